dm_access_unit: RTL and testbench

- Initiator-side access unit between the CPU datapath and the word-wide data memory.
- Accepts byte, halfword and word load/store requests over a valid/ready handshake and checks alignment and range.
- Drives the word-only memory interface; sub-word stores use read-modify-write.
- Returns the load result, sign- or zero-extended, with a one-cycle response pulse.

---
 rtl/dm_access_unit_pkg.sv | 39 +++
 rtl/dm_lane_mux.sv | 72 +++++++
 rtl/dm_access_unit.sv | 193 +++++++++++++++++++
 tb/tb_dm_access_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_access_unit_pkg.sv
// Shared definitions for the data-memory access unit: access size codes,
// FSM state encoding, default memory size and the request legality check.
package dm_access_unit_pkg;

    // Access size codes carried on req_size
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_ILL  = 2'd3;

    // Default data memory size in bytes
    localparam int unsigned MEM_BYTES_DEF = 32'd4096;

    // Access unit FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } dm_state_e;

    // A request is rejected for an illegal size, a misaligned half/word
    // address, or any address at or beyond the end of memory.
    function automatic logic dm_req_err(
        input logic [1:0]  size,
        input logic [31:0] addr,
        input logic [31:0] mem_bytes
    );
        logic align_err_s;
        case (size)
            SZ_BYTE: align_err_s = 1'b0;
            SZ_HALF: align_err_s = addr[0];
            SZ_WORD: align_err_s = (addr[1:0] != 2'b00);
            default: align_err_s = 1'b1;
        endcase
        return align_err_s | (addr >= mem_bytes);
    endfunction

endpackage

// File: rtl/dm_lane_mux.sv
// Byte-lane steering for the access unit: extracts and extends the
// addressed lane(s) of a memory word for loads, and merges store data into
// the addressed lane(s) of a memory word for sub-word stores.
// Lanes are little-endian: offset 0 is bits 7:0.
module dm_lane_mux
    import dm_access_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte and halfword out of the memory word
    always_comb begin
        byte_s = 8'h00;
        case (offset)
            2'd0:    byte_s = word[7:0];
            2'd1:    byte_s = word[15:8];
            2'd2:    byte_s = word[23:16];
            2'd3:    byte_s = word[31:24];
            default: byte_s = 8'h00;
        endcase
        if (offset[1]) begin
            half_s = word[31:16];
        end else begin
            half_s = word[15:0];
        end
    end

    // Extend the selected lane(s) to a full word for loads
    always_comb begin
        load_data = 32'h0000_0000;
        case (size)
            SZ_BYTE: load_data = {{24{sign_ext & byte_s[7]}}, byte_s};
            SZ_HALF: load_data = {{16{sign_ext & half_s[15]}}, half_s};
            SZ_WORD: load_data = word;
            default: load_data = 32'h0000_0000;
        endcase
    end

    // Replace only the addressed lane(s) of the old word for sub-word stores
    always_comb begin
        store_data = word;
        case (size)
            SZ_BYTE: begin
                case (offset)
                    2'd0:    store_data[7:0]   = wdata[7:0];
                    2'd1:    store_data[15:8]  = wdata[7:0];
                    2'd2:    store_data[23:16] = wdata[7:0];
                    2'd3:    store_data[31:24] = wdata[7:0];
                    default: store_data        = word;
                endcase
            end
            SZ_HALF: begin
                if (offset[1]) begin
                    store_data[31:16] = wdata;
                end else begin
                    store_data[15:0] = wdata;
                end
            end
            default: store_data = word;
        endcase
    end

endmodule

// File: rtl/dm_access_unit.sv
// Initiator-side data memory access unit. Accepts byte/half/word loads and
// stores over a valid/ready handshake, rejects illegal requests without
// touching memory, performs read-modify-write for sub-word stores on the
// word-only memory port, and returns a one-cycle response pulse.
// All outputs are registered from the next state, so each strobe is high
// exactly while the FSM sits in the matching state.
module dm_access_unit
    import dm_access_unit_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
    parameter int unsigned DM_IDX_W  = 32'd10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_din,
    output logic        dm_we,
    output logic        dm_re,
    input  logic [31:0] dm_dout
);

    // Byte-address bits that reach memory: word index plus lane offset.
    // Legal addresses are below MEM_BYTES, so higher bits are always zero.
    localparam int unsigned AW = DM_IDX_W + 32'd2;

    dm_state_e state_r;
    dm_state_e next_state_s;

    // Latched request
    logic          we_r;
    logic [1:0]    size_r;
    logic          signed_r;
    logic [AW-1:0] addr_r;
    logic [15:0]   wdata_r;

    // Output registers
    logic          req_ready_r;
    logic          resp_valid_r;
    logic [31:0]   resp_rdata_r;
    logic          resp_err_r;
    logic [31:0]   dm_addr_r;
    logic [31:0]   dm_din_r;
    logic          dm_we_r;
    logic          dm_re_r;

    // Decoded helpers
    logic          req_err_s;
    logic          accept_s;
    logic [31:0]   req_word_addr_s;
    logic [31:0]   lat_word_addr_s;
    logic [31:0]   load_data_s;
    logic [31:0]   store_data_s;

    assign req_err_s       = dm_req_err(req_size, req_addr, 32'(MEM_BYTES));
    assign req_word_addr_s = {{(32 - AW){1'b0}}, req_addr[AW-1:2], 2'b00};
    assign lat_word_addr_s = {{(32 - AW){1'b0}}, addr_r[AW-1:2], 2'b00};

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;
    assign dm_addr    = dm_addr_r;
    assign dm_din     = dm_din_r;
    assign dm_we      = dm_we_r;
    assign dm_re      = dm_re_r;

    // Lane steering works on live memory data while in RD; its results are
    // captured into resp_rdata (loads) or dm_din (sub-word stores).
    dm_lane_mux u_lane_mux (
        .word       (dm_dout),
        .offset     (addr_r[1:0]),
        .size       (size_r),
        .sign_ext   (signed_r),
        .wdata      (wdata_r),
        .load_data  (load_data_s),
        .store_data (store_data_s)
    );

    // Next-state decode: errors skip memory, word stores skip the read
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    accept_s = 1'b1;
                    if (req_err_s) begin
                        next_state_s = ST_RESP;
                    end else if (req_we && (req_size == SZ_WORD)) begin
                        next_state_s = ST_WR;
                    end else begin
                        next_state_s = ST_RD;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RD: begin
                if (we_r) begin
                    next_state_s = ST_WR;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            ST_WR:   next_state_s = ST_RESP;
            ST_RESP: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Capture the request fields on the accept edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_r     <= 1'b0;
            size_r   <= 2'b00;
            signed_r <= 1'b0;
            addr_r   <= '0;
            wdata_r  <= 16'h0000;
        end else if (accept_s) begin
            we_r     <= req_we;
            size_r   <= req_size;
            signed_r <= req_signed;
            addr_r   <= req_addr[AW-1:0];
            wdata_r  <= req_wdata[15:0];
        end else begin
            we_r     <= we_r;
            size_r   <= size_r;
            signed_r <= signed_r;
            addr_r   <= addr_r;
            wdata_r  <= wdata_r;
        end
    end

    // Output registers, loaded with the values of the state being entered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            resp_err_r   <= 1'b0;
            dm_addr_r    <= 32'h0000_0000;
            dm_din_r     <= 32'h0000_0000;
            dm_we_r      <= 1'b0;
            dm_re_r      <= 1'b0;
        end else begin
            req_ready_r  <= (next_state_s == ST_IDLE);
            resp_valid_r <= (next_state_s == ST_RESP);
            dm_re_r      <= (next_state_s == ST_RD);
            dm_we_r      <= (next_state_s == ST_WR);
            case (state_r)
                ST_IDLE: begin
                    resp_err_r   <= accept_s & req_err_s;
                    resp_rdata_r <= 32'h0000_0000;
                    dm_addr_r    <= ((next_state_s == ST_RD) || (next_state_s == ST_WR))
                                    ? req_word_addr_s : 32'h0000_0000;
                    dm_din_r     <= (next_state_s == ST_WR) ? req_wdata : 32'h0000_0000;
                end
                ST_RD: begin
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= we_r ? 32'h0000_0000 : load_data_s;
                    dm_addr_r    <= we_r ? lat_word_addr_s : 32'h0000_0000;
                    dm_din_r     <= we_r ? store_data_s : 32'h0000_0000;
                end
                default: begin
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= 32'h0000_0000;
                    dm_addr_r    <= 32'h0000_0000;
                    dm_din_r     <= 32'h0000_0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_unit.sv
// Scoreboard bench for dm_access_unit: a byte-array reference memory
// predicts every response; a monitor pops expectations on resp_valid.
module tb_dm_access_unit;

    localparam logic [31:0] MEMB = 32'd4096;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] dm_addr;
    logic [31:0] dm_din;
    logic        dm_we;
    logic        dm_re;
    logic [31:0] dm_dout;

    dm_access_unit #(.MEM_BYTES(32'd4096), .DM_IDX_W(32'd10)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .dm_addr(dm_addr), .dm_din(dm_din),
        .dm_we(dm_we), .dm_re(dm_re), .dm_dout(dm_dout)
    );

    always #5 clk = ~clk;

    // Word-wide memory seen by the DUT
    logic [31:0] mem [0:1023];
    assign dm_dout = mem[dm_addr[11:2]];
    always @(posedge clk) if (dm_we) mem[dm_addr[11:2]] <= dm_din;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Reference model: flat little-endian byte array
    logic [7:0] ref_bytes [0:4095];

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          n_rd;
        int          n_wr;
        logic [31:0] wr_word;
        logic [31:0] waddr;
        int          acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_pass = 0;
    int last_resp_cyc = -100;
    int rd_cnt = 0;
    int wr_cnt = 0;
    logic [31:0] wr_seen = 32'd0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] waddr);
        logic [31:0] w = 32'd0;
        for (int i = 0; i < 4; i++) w |= 32'(ref_bytes[waddr + 32'(i)]) << (8 * i);
        return w;
    endfunction

    // Predict the response of one request and apply its effect on memory
    function automatic exp_t model(input logic we, input logic [1:0] size, input logic sgn,
                                   input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        int n;
        longint unsigned v;
        e.err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
                (size == 2'd2 && addr % 4 != 0) || (addr >= MEMB);
        e.rdata = 32'd0; e.n_rd = 0; e.n_wr = 0; e.wr_word = 32'd0;
        e.waddr = addr & 32'hFFFF_FFFC; e.acc_cyc = 0; e.lat = 1;
        if (!e.err) begin
            n = 1 << size;
            if (!we) begin
                e.lat = 2; e.n_rd = 1; v = 64'd0;
                for (int i = 0; i < n; i++) v |= 64'(ref_bytes[addr + 32'(i)]) << (8 * i);
                if (sgn && ((v >> (8 * n - 1)) & 64'd1) == 64'd1) v = v | ~((64'd1 << (8 * n)) - 64'd1);
                e.rdata = v[31:0];
            end else begin
                e.n_wr = 1;
                e.lat  = (n == 4) ? 2 : 3;
                e.n_rd = (n == 4) ? 0 : 1;
                for (int i = 0; i < n; i++) ref_bytes[addr + 32'(i)] = 8'((wdata >> (8 * i)) & 32'hFF);
                e.wr_word = ref_word(e.waddr);
            end
        end
        return e;
    endfunction

    // Present a request and hold it until accepted; push its expectation
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input bit b2b, input bit use_k, input logic [31:0] k);
        exp_t e;
        bit acc = 1'b0;
        @(negedge clk);
        req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        for (int b = 0; b < 20 && !acc; b++) begin
            if (req_ready) begin
                acc = 1'b1;
                e = model(we, size, sgn, addr, wdata);
                if (use_k) begin
                    if (we) e.wr_word = k;
                    else e.rdata = k;
                end
                e.acc_cyc = cycle;
                if (b2b) check("b2b_accept_cycle", 32'(cycle), 32'(last_resp_cyc + 1));
                @(posedge clk);
                exp_q.push_back(e);
            end else begin
                @(negedge clk);
            end
        end
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        @(negedge clk);
        req_valid = 1'b0;
        for (int b = 0; b < 20 && exp_q.size() != 0; b++) @(negedge clk);
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: handshake/strobe sanity every cycle, scoreboard on resp_valid
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                rd_cnt = 0; wr_cnt = 0;
            end else begin
                check("req_ready", 32'(req_ready), 32'(exp_q.size() == 0));
                if (dm_re) rd_cnt++;
                if (dm_we) begin wr_cnt++; wr_seen = dm_din; end
                if (dm_re || dm_we) begin
                    if (exp_q.size() == 0) check("access_while_idle", 32'd1, 32'd0);
                    else check("dm_addr", dm_addr, exp_q[0].waddr);
                end
                if (resp_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_resp", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_err", 32'(resp_err), 32'(e.err));
                        check("resp_rdata", resp_rdata, e.rdata);
                        check("latency", 32'(cycle - e.acc_cyc), 32'(e.lat));
                        check("mem_reads", 32'(rd_cnt), 32'(e.n_rd));
                        check("mem_writes", 32'(wr_cnt), 32'(e.n_wr));
                        if (e.n_wr == 1) check("dm_din", wr_seen, e.wr_word);
                    end
                    rd_cnt = 0; wr_cnt = 0;
                    last_resp_cyc = cycle;
                end
            end
        end
    end

    initial begin
        logic [31:0] w, old_word, a, d;
        logic [7:0] old_byte;
        logic [1:0] sz;
        bit seen, b2b;
        for (int i = 0; i < 1024; i++) begin
            w = $urandom;
            mem[i] <= w;
            for (int j = 0; j < 4; j++) ref_bytes[4 * i + j] = 8'((w >> (8 * j)) & 32'hFF);
        end
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_dm_we", 32'(dm_we), 32'd0);
        check("rst_dm_re", 32'(dm_re), 32'd0);
        check("rst_dm_addr", dm_addr, 32'd0);
        check("rst_dm_din", dm_din, 32'd0);
        reset = 1'b1;

        // Directed: word store/load, byte RMW, extension, errors, boundaries
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 32'hDEADBEEF);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF);
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 1'b1, 1'b1, 32'h11223344);
        issue(1'b1, 2'd0, 1'b0, 32'h12, 32'h000000AA, 1'b1, 1'b1, 32'h11AA3344);
        issue(1'b0, 2'd0, 1'b1, 32'h12, 32'h0, 1'b1, 1'b1, 32'hFFFFFFAA);
        issue(1'b0, 2'd0, 1'b0, 32'h12, 32'h0, 1'b1, 1'b1, 32'h000000AA);
        issue(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b1, 1'b1, 32'h000011AA);
        issue(1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 1'b1, 1'b0, 32'h0);
        issue(1'b1, 2'd1, 1'b0, 32'h11, 32'h1234, 1'b1, 1'b0, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 1'b1, 1'b0, 32'h0);
        issue(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h0);
        issue(1'b1, 2'd2, 1'b0, 32'hFFC, 32'hCAFEF00D, 1'b1, 1'b1, 32'hCAFEF00D);
        issue(1'b0, 2'd2, 1'b0, 32'hFFC, 32'h0, 1'b1, 1'b1, 32'hCAFEF00D);
        issue(1'b0, 2'd0, 1'b1, 32'hFFF, 32'h0, 1'b1, 1'b1, 32'hFFFFFFCA);
        issue(1'b0, 2'd0, 1'b0, 32'h1000, 32'h0, 1'b1, 1'b0, 32'h0);
        issue(1'b1, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h5, 1'b1, 1'b0, 32'h0);
        drain();

        // Reset while a byte store sits in WR: write must be abandoned
        old_word = mem[8];
        old_byte = ref_bytes[32'h21];
        issue(1'b1, 2'd0, 1'b0, 32'h21, 32'h5A, 1'b0, 1'b0, 32'h0);
        seen = 1'b0;
        for (int b = 0; b < 10 && !seen; b++) begin
            @(negedge clk);
            if (dm_we) seen = 1'b1;
        end
        if (!seen) check("wr_state_timeout", 32'd0, 32'd1);
        #2 reset = 1'b0;
        req_valid = 1'b0;
        #1;
        check("abort_dm_we", 32'(dm_we), 32'd0);
        check("abort_dm_re", 32'(dm_re), 32'd0);
        check("abort_dm_din", dm_din, 32'd0);
        check("abort_dm_addr", dm_addr, 32'd0);
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        exp_q.delete();
        ref_bytes[32'h21] = old_byte;
        @(posedge clk);
        #1 check("abort_mem_word", mem[8], old_word);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_ready", 32'(req_ready), 32'd1);
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0);

        // Randomized traffic with occasional idle gaps
        b2b = 1'b1;
        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 9))
                7: a = 32'($urandom_range(4080, 4095));
                8: a = 32'($urandom_range(4096, 4200));
                9: a = $urandom;
                default: a = 32'($urandom_range(0, 127));
            endcase
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            d = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                idle($urandom_range(1, 3));
                b2b = 1'b0;
            end
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, d, b2b, 1'b0, 32'h0);
            b2b = 1'b1;
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #500000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
